// File: rtl/centroid_writeback.sv
// centroid_writeback
//   Consumer end of the k-means update stream. Buffers 512-bit updated-centroid
//   cachelines in a local FIFO and drains them to the memory write engine as
//   addressed write requests. Counts iterations written back and pulses um_done
//   once the configured iteration count is complete.
//
//   Optional feature (macro CENTROID_HISTORY_EN): each iteration is written to
//   its own region and the extra output hist_bytes reports the total size.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start_operator             pulse: latch config and start a run (IDLE only)
//   num_iteration              iterations to write back (0 treated as 1)
//   centroid_base_addr         64-B aligned byte address of centroid region
//   num_cluster, data_dim      K and D (32-bit words per centroid)
//   updated_centroid*          input cacheline stream (valid/last, no backpressure)
//   wr_addr/wr_data/wr_last    write request payload
//   wr_valid/wr_ready          write request handshake
//   um_done                    one-cycle completion pulse
//   busy                       run in progress
//   iter_cnt                   completed iterations in the current run
//   err_overflow               sticky: cacheline dropped on full FIFO
//   err_len_mismatch           sticky: iteration length != expected length
//   hist_bytes                 (CENTROID_HISTORY_EN only) 64*expected_cl*N
module centroid_writeback #(
  parameter int FIFO_DEPTH    = 16,
  parameter int ADDR_W        = 64,
  parameter int NUM_CLUSTER_W = 5,
  parameter int DATA_DIM_W    = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_operator,
  input  logic [15:0]              num_iteration,
  input  logic [ADDR_W-1:0]        centroid_base_addr,
  input  logic [NUM_CLUSTER_W-1:0] num_cluster,
  input  logic [DATA_DIM_W-1:0]    data_dim,
  input  logic [511:0]             updated_centroid,
  input  logic                     updated_centroid_valid,
  input  logic                     updated_centroid_last,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [511:0]             wr_data,
  output logic                     wr_valid,
  output logic                     wr_last,
  input  logic                     wr_ready,
  output logic                     um_done,
  output logic                     busy,
  output logic [15:0]              iter_cnt,
  output logic                     err_overflow,
  output logic                     err_len_mismatch
`ifdef CENTROID_HISTORY_EN
  ,
  output logic [ADDR_W-1:0]        hist_bytes
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CL_W   = NUM_CLUSTER_W + DATA_DIM_W;
  localparam int PROD_W = CL_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state;

  logic [511:0]      fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W-1:0]  rd_idx;
  logic              fifo_empty;
  logic              fifo_full;

  logic [ADDR_W-1:0] base_q;
  logic [CL_W-1:0]   exp_cl;
  logic [15:0]       n_q;
  logic [CL_W-1:0]   cl_idx;
  logic [15:0]       in_iter;
  logic              in_done;

  logic              accept_in;
  logic              push;
  logic              pop;
  logic              drop;

  logic [PROD_W-1:0] prod_round;
  logic [CL_W-1:0]   exp_cl_next;
  logic [15:0]       n_next;
  logic [ADDR_W-1:0] cl_offset;

  // Full-width K*D, rounded up to whole 16-word cachelines.
  assign prod_round  = PROD_W'(num_cluster) * PROD_W'(data_dim) + PROD_W'(15);
  assign exp_cl_next = CL_W'(prod_round >> 4);
  assign n_next      = (num_iteration == 16'd0) ? 16'd1 : num_iteration;

  assign rd_idx     = rd_ptr[PTR_W-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign wr_valid = (state == S_RUN) && !fifo_empty;
  assign pop      = wr_valid && wr_ready;

  // Input is only taken while running and before the final iteration's last
  // flag has been seen; a full FIFO still accepts when a pop frees a slot.
  assign accept_in = (state == S_RUN) && updated_centroid_valid && !in_done;
  assign push      = accept_in && (!fifo_full || pop);
  assign drop      = accept_in && fifo_full && !pop;

  // Payload is zero when nothing is offered so outputs read 0 out of reset.
  assign wr_data = wr_valid ? fifo_data[rd_idx] : '0;
  assign wr_last = wr_valid ? fifo_last[rd_idx] : 1'b0;

`ifdef CENTROID_HISTORY_EN
  assign cl_offset = ADDR_W'(iter_cnt) * ADDR_W'(exp_cl) + ADDR_W'(cl_idx);
`else
  assign cl_offset = ADDR_W'(cl_idx);
`endif
  assign wr_addr = base_q + (cl_offset << 6);

  // Storage array: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr[PTR_W-1:0]] <= updated_centroid;
      fifo_last[wr_ptr[PTR_W-1:0]] <= updated_centroid_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      base_q           <= '0;
      exp_cl           <= '0;
      n_q              <= '0;
      cl_idx           <= '0;
      in_iter          <= '0;
      in_done          <= 1'b0;
      iter_cnt         <= '0;
      um_done          <= 1'b0;
      busy             <= 1'b0;
      err_overflow     <= 1'b0;
      err_len_mismatch <= 1'b0;
`ifdef CENTROID_HISTORY_EN
      hist_bytes       <= '0;
`endif
    end else begin
      um_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_operator) begin
            state            <= S_RUN;
            busy             <= 1'b1;
            base_q           <= centroid_base_addr;
            exp_cl           <= exp_cl_next;
            n_q              <= n_next;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            cl_idx           <= '0;
            in_iter          <= '0;
            in_done          <= 1'b0;
            iter_cnt         <= '0;
            err_overflow     <= 1'b0;
            err_len_mismatch <= 1'b0;
`ifdef CENTROID_HISTORY_EN
            hist_bytes       <= (ADDR_W'(exp_cl_next) * ADDR_W'(n_next)) << 6;
`endif
          end
        end

        S_RUN: begin
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (drop) err_overflow <= 1'b1;

          // A dropped last flag still ends the iteration on the input side.
          if (accept_in && updated_centroid_last) begin
            in_iter <= in_iter + 16'd1;
            if (in_iter + 16'd1 == n_q) in_done <= 1'b1;
          end

          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (fifo_last[rd_idx]) begin
              cl_idx   <= '0;
              iter_cnt <= iter_cnt + 16'd1;
              if (cl_idx + CL_W'(1) != exp_cl) err_len_mismatch <= 1'b1;
              if (iter_cnt + 16'd1 == n_q) begin
                state   <= S_DRAIN;
                um_done <= 1'b1;
              end
            end else begin
              cl_idx <= cl_idx + CL_W'(1);
            end
          end
        end

        S_DRAIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_writeback.sv
// tb_centroid_writeback
//   Directed bench for centroid_writeback: reset state, two-iteration
//   write-back with and without write stalls, FIFO overflow, length mismatch,
//   num_iteration=0 with an ignored restart, and mid-run reset.
module tb_centroid_writeback;

  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_operator;
  logic [15:0]       num_iteration;
  logic [ADDR_W-1:0] centroid_base_addr;
  logic [4:0]        num_cluster;
  logic [8:0]        data_dim;
  logic [511:0]      updated_centroid;
  logic              updated_centroid_valid;
  logic              updated_centroid_last;
  logic [ADDR_W-1:0] wr_addr;
  logic [511:0]      wr_data;
  logic              wr_valid;
  logic              wr_last;
  logic              wr_ready;
  logic              um_done;
  logic              busy;
  logic [15:0]       iter_cnt;
  logic              err_overflow;
  logic              err_len_mismatch;
`ifdef CENTROID_HISTORY_EN
  logic [ADDR_W-1:0] hist_bytes;
`endif

  centroid_writeback #(
    .FIFO_DEPTH   (16),
    .ADDR_W       (ADDR_W),
    .NUM_CLUSTER_W(5),
    .DATA_DIM_W   (9)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start_operator        (start_operator),
    .num_iteration         (num_iteration),
    .centroid_base_addr    (centroid_base_addr),
    .num_cluster           (num_cluster),
    .data_dim              (data_dim),
    .updated_centroid      (updated_centroid),
    .updated_centroid_valid(updated_centroid_valid),
    .updated_centroid_last (updated_centroid_last),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .wr_valid              (wr_valid),
    .wr_last               (wr_last),
    .wr_ready              (wr_ready),
    .um_done               (um_done),
    .busy                  (busy),
    .iter_cnt              (iter_cnt),
    .err_overflow          (err_overflow),
    .err_len_mismatch      (err_len_mismatch)
`ifdef CENTROID_HISTORY_EN
    ,
    .hist_bytes            (hist_bytes)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int um_cnt   = 0;
  int um_cyc   = 0;
  int hs_cyc   = 0;
  bit stall_mode = 1'b0;

  logic [ADDR_W-1:0] q_addr [$];
  logic [511:0]      q_data [$];
  logic              q_last [$];
  logic [15:0]       q_iter [$];

  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [511:0]      prev_data;
  logic              prev_last;

  function automatic logic [511:0] mk(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(i);
    return {16{w}};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe at the falling edge, then advance to just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (stall_mode && prev_stall) begin
      check("stall_valid", 512'(wr_valid), 512'(1));
      check("stall_addr", 512'(wr_addr), 512'(prev_addr));
      check("stall_data", wr_data, prev_data);
      check("stall_last", 512'(wr_last), 512'(prev_last));
    end
    prev_stall = wr_valid && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
    prev_last  = wr_last;
    if (wr_valid && wr_ready) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_last.push_back(wr_last);
      q_iter.push_back(iter_cnt);
      hs_cyc = cyc;
    end
    if (um_done) begin
      um_cnt++;
      um_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (stall_mode) wr_ready = (cyc % 3 == 0);
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    q_iter.delete();
    um_cnt = 0;
    prev_stall = 1'b0;
  endtask

  task automatic start_op(input int k, input int d, input int n, input logic [ADDR_W-1:0] base);
    num_cluster        = 5'(k);
    data_dim           = 9'(d);
    num_iteration      = 16'(n);
    centroid_base_addr = base;
    start_operator     = 1'b1;
    tick();
    start_operator     = 1'b0;
  endtask

  task automatic send(input logic [511:0] d, input logic last);
    updated_centroid       = d;
    updated_centroid_valid = 1'b1;
    updated_centroid_last  = last;
    tick();
    updated_centroid_valid = 1'b0;
    updated_centroid_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && um_cnt == 0; i++) tick();
    for (int i = 0; i < 3; i++) tick();
  endtask

  // Expected write sequence: ecl cachelines per iteration, data mk(doff+i).
  task automatic check_writes(input int n, input logic [ADDR_W-1:0] base, input int ecl, input int doff);
    logic [ADDR_W-1:0] ea;
    check("write_count", 512'(q_addr.size()), 512'(n));
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      ea = base + ADDR_W'(64 * (i % ecl));
`ifdef CENTROID_HISTORY_EN
      ea = ea + ADDR_W'(64 * ecl * (i / ecl));
`endif
      check($sformatf("addr[%0d]", i), 512'(q_addr[i]), 512'(ea));
      check($sformatf("data[%0d]", i), q_data[i], mk(doff + i));
      check($sformatf("last[%0d]", i), 512'(q_last[i]), 512'((i % ecl) == ecl - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_valid"}, 512'(wr_valid), 512'(0));
    check({tag, "_wr_addr"}, 512'(wr_addr), 512'(0));
    check({tag, "_wr_data"}, wr_data, 512'(0));
    check({tag, "_wr_last"}, 512'(wr_last), 512'(0));
    check({tag, "_um_done"}, 512'(um_done), 512'(0));
    check({tag, "_busy"}, 512'(busy), 512'(0));
    check({tag, "_iter_cnt"}, 512'(iter_cnt), 512'(0));
    check({tag, "_err_ovf"}, 512'(err_overflow), 512'(0));
    check({tag, "_err_len"}, 512'(err_len_mismatch), 512'(0));
  endtask

  task automatic two_iter_run(input string tag);
    clear_log();
    start_op(4, 16, 2, 64'h1000);
    check({tag, "_busy"}, 512'(busy), 512'(1));
`ifdef CENTROID_HISTORY_EN
    check({tag, "_hist_bytes"}, 512'(hist_bytes), 512'(64'h200));
`endif
    for (int i = 0; i < 8; i++) send(mk(i), (i % 4) == 3);
    wait_done(60);
    check_writes(8, 64'h1000, 4, 0);
    if (q_iter.size() > 4) check({tag, "_iter_mid"}, 512'(q_iter[4]), 512'(1));
    check({tag, "_um_cnt"}, 512'(um_cnt), 512'(1));
    check({tag, "_um_timing"}, 512'(um_cyc), 512'(hs_cyc + 1));
    check({tag, "_iter_cnt"}, 512'(iter_cnt), 512'(2));
    check({tag, "_busy_end"}, 512'(busy), 512'(0));
    check({tag, "_err_ovf"}, 512'(err_overflow), 512'(0));
    check({tag, "_err_len"}, 512'(err_len_mismatch), 512'(0));
  endtask

  initial begin
    rst_n                  = 1'b0;
    start_operator         = 1'b0;
    num_iteration          = '0;
    centroid_base_addr     = '0;
    num_cluster            = '0;
    data_dim               = '0;
    updated_centroid       = '0;
    updated_centroid_valid = 1'b0;
    updated_centroid_last  = 1'b0;
    wr_ready               = 1'b1;

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Two iterations, always ready
    two_iter_run("run1");

    // Same run with write-side stalls
    stall_mode = 1'b1;
    two_iter_run("stall");
    stall_mode = 1'b0;
    wr_ready   = 1'b1;
    tick();

    // Overflow: 20 cachelines into a 16-deep FIFO with no drain
    clear_log();
    wr_ready = 1'b0;
    start_op(4, 16, 1, 64'h4000);
    for (int i = 0; i < 20; i++) send(mk(100 + i), 1'b0);
    tick();
    check("ovf_flag", 512'(err_overflow), 512'(1));
    check("ovf_valid", 512'(wr_valid), 512'(1));
    wr_ready = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    check_writes(16, 64'h4000, 64, 100);
    check("ovf_empty", 512'(wr_valid), 512'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Length mismatch: K=2, D=20 -> 3 expected, 2 sent
    clear_log();
    start_op(2, 20, 1, 64'h8000);
    send(mk(200), 1'b0);
    send(mk(201), 1'b1);
    wait_done(30);
    check("len_err", 512'(err_len_mismatch), 512'(1));
    check("len_iter", 512'(iter_cnt), 512'(1));
    check("len_um", 512'(um_cnt), 512'(1));
    check("len_ovf", 512'(err_overflow), 512'(0));
    check("len_writes", 512'(q_addr.size()), 512'(2));

    // num_iteration=0, restart while busy ignored, trailing input ignored
    clear_log();
    start_op(1, 16, 0, 64'h2000);
    start_op(2, 16, 5, 64'h9000);
    send(mk(40), 1'b1);
    send(mk(41), 1'b0);
    wait_done(30);
    send(mk(42), 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check_writes(1, 64'h2000, 1, 40);
    check("n0_um", 512'(um_cnt), 512'(1));
    check("n0_iter", 512'(iter_cnt), 512'(1));
    check("n0_busy", 512'(busy), 512'(0));
    check("n0_ovf", 512'(err_overflow), 512'(0));

    // Mid-run reset discards pending data; restart writes from base
    clear_log();
    start_op(4, 16, 1, 64'h3000);
    send(mk(50), 1'b0);
    send(mk(51), 1'b0);
    tick();
    tick();
    check("mid_writes", 512'(q_addr.size()), 512'(2));
    wr_ready = 1'b0;
    send(mk(52), 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    wr_ready = 1'b1;
    tick();
    clear_log();
    start_op(4, 16, 1, 64'h3000);
    for (int i = 0; i < 4; i++) send(mk(60 + i), i == 3);
    wait_done(30);
    check_writes(4, 64'h3000, 4, 60);
    check("restart_um", 512'(um_cnt), 512'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/centroid_writeback.md
Name: centroid_writeback

Overview:
- Consumer end of the k-means update stream: accepts 512-bit updated-centroid cachelines (valid/last, no backpressure) and buffers them in a local FIFO.
- Drains the FIFO to the memory write engine as addressed write requests over a valid/ready handshake.
- Counts k-means iterations and generates the um_done pulse that stops the k-means operator once the configured iteration count has been written back.

Parameters:
- FIFO_DEPTH, 16, cacheline FIFO entries; power of two, minimum 4.
- ADDR_W, 64, write address width.
- NUM_CLUSTER_W, 5, width of num_cluster.
- DATA_DIM_W, 9, width of data_dim.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start_operator  in  1  pulse; latches config, starts a run
- num_iteration  in  16  iterations to write back; 0 is treated as 1
- centroid_base_addr  in  ADDR_W  byte address of the centroid region, 64-B aligned
- num_cluster  in  NUM_CLUSTER_W  K
- data_dim  in  DATA_DIM_W  D, 32-bit words per centroid
- updated_centroid  in  512  update cacheline
- updated_centroid_valid  in  1  cacheline valid
- updated_centroid_last  in  1  last cacheline of the iteration
- wr_addr  out  ADDR_W  write address
- wr_data  out  512  write data
- wr_valid  out  1  write request valid
- wr_last  out  1  last write of the iteration
- wr_ready  in  1  write engine accepts
- um_done  out  1  single-cycle completion pulse
- busy  out  1  run in progress
- iter_cnt  out  16  completed iterations in the current run
- err_overflow  out  1  sticky: cacheline dropped
- err_len_mismatch  out  1  sticky: iteration length differs from the expected length

Behaviour:
- Reset values: all outputs are 0; FIFO is empty; state is IDLE. Reset asserted mid-run aborts the run immediately, discards FIFO contents and clears all counters and errors.
- Config latch on start_operator in IDLE:
  - K, D, base address and N = max(num_iteration, 1) are latched.
  - expected_cl = ceil(K*D/16), computed with full-width arithmetic and no truncation.
  - iter_cnt, the per-iteration cacheline index and both error flags are cleared.
  - start_operator outside IDLE is ignored.
- States:
  - IDLE: busy=0. Input cachelines are ignored, with no push and no error. start_operator moves to RUN.
  - RUN: busy=1. Every valid input pushes {data, last} into the FIFO. The pop handshake moves to DRAIN when the last popped entry completes iteration N.
  - DRAIN: the single-cycle state that asserts um_done. Next state is IDLE; busy falls on that transition.
- FIFO:
  - Push occurs when the input is valid and the FIFO is not full.
  - When the FIFO is full, a same-cycle pop frees the slot and the push is accepted.
  - When the FIFO is full with no pop, the cacheline is dropped and err_overflow is set.
  - wr_valid = FIFO not empty, in RUN. Data pushed at cycle t is visible on wr_* at t+1 at the earliest (registered output).
- Handshake:
  - A write completes when wr_valid and wr_ready are both high.
  - wr_addr, wr_data and wr_last are held stable while wr_valid=1 and wr_ready=0.
  - wr_valid never drops without a handshake.
- Addressing:
  - wr_addr = base + 64*cl_idx. cl_idx increments per handshake and resets to 0 after a handshake with wr_last=1.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - wr_last carries the stored input last flag.
- Iteration end: the handshake with wr_last=1 increments iter_cnt. If (cl_idx+1) != expected_cl, err_len_mismatch is set; the iteration still counts.
- um_done: asserted exactly one cycle, the cycle after the handshake that completes iteration N.
- Cachelines still arriving after the final input last flag of iteration N are ignored.

Optional Feature:
- Macro: CENTROID_HISTORY_EN.
- Defined: each iteration is written to its own region, wr_addr = base + 64*(iter_cnt*expected_cl + cl_idx), preserving all intermediate centroids. An extra output port, hist_bytes (ADDR_W bits), reports 64*expected_cl*N and is valid from the cycle after start_operator until the next start_operator.
- Undefined: every iteration overwrites the same region starting at base, and hist_bytes does not exist.

Test Plan:
- K=4, D=16, N=2, base=0x1000, wr_ready=1, 4 cachelines per iteration -> 8 writes to 0x1000/0x1040/0x1080/0x10C0, twice. wr_last is set on the 4th and 8th writes; iter_cnt steps 1→2; um_done is high for one cycle right after the 8th handshake; no errors.
- Same as the first scenario with wr_ready toggled 1-in-3 -> identical address/data sequence; wr_* stays stable while stalled; no loss.
- FIFO_DEPTH=16, wr_ready=0, 20 back-to-back cachelines -> 16 stored, err_overflow=1. Releasing wr_ready yields exactly 16 writes.
- K=2, D=20 (expected_cl=3), 2 cachelines with last on the 2nd -> err_len_mismatch=1, iter_cnt=1.
- num_iteration=0, K=1, D=16 -> run completes after 1 iteration with um_done; a second start_operator while busy is ignored.
- rst_n low for 1 cycle after 2 of 4 writes -> all outputs 0, FIFO empty. A new start then yields writes from base again.
- With CENTROID_HISTORY_EN, K=4, D=16, N=2, base=0 -> the second iteration writes to 0x100–0x1C0; hist_bytes=0x200.
